// File: rtl/fifo_rd.sv
// Read-side pointer and status controller of an asynchronous FIFO.
// It keeps the binary read pointer and its gray copy, and derives the empty, level and underflow status.
module fifo_rd #(
    parameter int P_SIZE   = 4,
    parameter int AE_LEVEL = 1
) (
    input  logic              r_clk,
    input  logic              r_rstn,
    input  logic              r_inc,
    input  logic [P_SIZE-1:0] sync_wr_ptr,
    output logic [P_SIZE-2:0] r_addr,
    output logic [P_SIZE-1:0] gray_rd_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [P_SIZE-1:0] r_level,
    output logic              underflow
);

    localparam logic [P_SIZE-1:0] AE_THRESH = P_SIZE'(AE_LEVEL);

    logic [P_SIZE-1:0] r_ptr_reg;
    logic [P_SIZE-1:0] gray_rd_ptr_reg;
    logic [P_SIZE-1:0] r_level_reg;
    logic              almost_empty_reg;
    logic              underflow_reg;

    logic              rd_en;
    logic [P_SIZE-1:0] r_ptr_next;
    logic [P_SIZE-1:0] gray_next;
    logic [P_SIZE-1:0] wr_bin;
    logic [P_SIZE-1:0] lvl_next;

    // Full-width compare, wrap bit included. It is pessimistic because
    // sync_wr_ptr lags the real write pointer.
    assign empty      = (sync_wr_ptr == gray_rd_ptr_reg);
    assign rd_en      = r_inc & ~empty;
    assign r_ptr_next = r_ptr_reg + {{(P_SIZE-1){1'b0}}, rd_en};

    genvar gi;
    generate
        for (gi = 0; gi < P_SIZE - 1; gi++) begin : g_bin2gray
            assign gray_next[gi] = r_ptr_next[gi] ^ r_ptr_next[gi+1];
        end
        assign gray_next[P_SIZE-1] = r_ptr_next[P_SIZE-1];

        // Each binary bit is the XOR of all gray bits at or above it.
        // Computing it this way avoids a ripple chain through one vector.
        for (gi = 0; gi < P_SIZE; gi++) begin : g_gray2bin
            assign wr_bin[gi] = ^sync_wr_ptr[P_SIZE-1:gi];
        end
    endgenerate

    assign lvl_next = wr_bin - r_ptr_next;

    // The binary and gray pointers load on the same edge. The gray copy never
    // falls behind, so the last entry cannot be read twice.
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            r_ptr_reg        <= '0;
            gray_rd_ptr_reg  <= '0;
            r_level_reg      <= '0;
            almost_empty_reg <= 1'b1;
            underflow_reg    <= 1'b0;
        end else begin
            r_ptr_reg        <= r_ptr_next;
            gray_rd_ptr_reg  <= gray_next;
            r_level_reg      <= lvl_next;
            almost_empty_reg <= (lvl_next <= AE_THRESH);
            underflow_reg    <= r_inc & empty;
        end
    end

    assign r_addr       = r_ptr_reg[P_SIZE-2:0];
    assign gray_rd_ptr  = gray_rd_ptr_reg;
    assign r_level      = r_level_reg;
    assign almost_empty = almost_empty_reg;
    assign underflow    = underflow_reg;

endmodule
